// File: rtl/ram_bus_arbiter_pkg.sv
// Shared constants for the byte-wide RAM/IO bus sequencer: FSM encoding,
// load/store size codes, IO window select and datapath widths.
package ram_bus_arbiter_pkg;

  localparam int AddrLen = 32;
  localparam int RegLen  = 32;

  localparam logic [1:0] IoSel = 2'b11;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_IF_RD   = 3'd1,
    ST_LS_RD   = 3'd2,
    ST_LS_WR   = 3'd3,
    ST_IO_WAIT = 3'd4
  } state_e;

  // Size code 11 is deliberately folded into the word case.
  function automatic logic [2:0] beats(input logic [1:0] size);
    case (size)
      SzByte:  return 3'd1;
      SzHalf:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/ram_bus_arbiter.sv
// Arbitrates fetch vs load/store onto the byte-wide RAM/IO bus and splits each
// access into byte beats against the 1-cycle-read-latency memory.
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int         ADDR_W = AddrLen,
  parameter logic [1:0] IO_SEL = IoSel
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [RegLen-1:0] if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [1:0]        ls_size,
  input  logic [RegLen-1:0] ls_wdata,
  output logic              ls_done,
  output logic [RegLen-1:0] ls_rdata
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [RegLen-1:0]   wdata_q, wdata_d;
  logic [RegLen-1:0]   data_q, data_d;
  logic [2:0]          ptr_i_q, ptr_i_d;
  logic [2:0]          ptr_c_q, ptr_c_d;
  logic [2:0]          n_q, n_d;
  logic                rdy_q;
  logic                if_valid_q, if_valid_d;
  logic                ls_done_q, ls_done_d;
  logic                rd_st;
  logic [2:0]          ptr_eff;

  // On the first cycle after a pause the read restarts from the first uncaptured byte.
  assign rd_st   = (state_q == ST_IF_RD) || (state_q == ST_LS_RD);
  assign ptr_eff = (rd_st && rdy && !rdy_q) ? ptr_c_q : ptr_i_q;

  assign ram_wr   = (state_q == ST_LS_WR) && rdy;
  assign ram_dout = ram_wr ? wdata_q[{ptr_i_q[1:0], 3'b000} +: 8] : 8'h00;
  assign ram_addr = (state_q == ST_IDLE) ? '0 : base_q + ADDR_W'(ptr_eff);

  assign if_valid = if_valid_q;
  assign ls_done  = ls_done_q;
  assign if_data  = data_q;
  assign ls_rdata = data_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    ptr_i_d    = ptr_i_q;
    ptr_c_d    = ptr_c_q;
    n_d        = n_q;
    if_valid_d = 1'b0;
    ls_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A requester whose done pulse is showing still holds its request; skip it.
        if (rdy) begin
          if (ls_req && !ls_done_q) begin
            base_d  = ls_addr;
            wdata_d = ls_wdata;
            data_d  = '0;
            n_d     = beats(ls_size);
            ptr_i_d = 3'd0;
            ptr_c_d = 3'd0;
            if (!ls_we)                        state_d = ST_LS_RD;
            else if (ls_addr[17:16] == IO_SEL) state_d = ST_IO_WAIT;
            else                               state_d = ST_LS_WR;
          end else if (if_req && !if_valid_q) begin
            base_d  = if_addr;
            data_d  = '0;
            n_d     = 3'd4;
            ptr_i_d = 3'd0;
            ptr_c_d = 3'd0;
            state_d = ST_IF_RD;
          end
        end
      end

      ST_IF_RD, ST_LS_RD: begin
        if ((state_q == ST_IF_RD) && if_flush) begin
          state_d = ST_IDLE;
          ptr_i_d = 3'd0;
          ptr_c_d = 3'd0;
        end else if (rdy) begin
          ptr_i_d = (ptr_eff < n_q) ? ptr_eff + 3'd1 : ptr_eff;
          if (rdy_q && (ptr_c_q < ptr_i_q)) begin
            data_d[{ptr_c_q[1:0], 3'b000} +: 8] = ram_din;
            ptr_c_d = ptr_c_q + 3'd1;
            if (ptr_c_q + 3'd1 == n_q) begin
              state_d = ST_IDLE;
              ptr_i_d = 3'd0;
              ptr_c_d = 3'd0;
              if (state_q == ST_IF_RD) if_valid_d = 1'b1;
              else                     ls_done_d  = 1'b1;
            end
          end
        end
      end

      ST_LS_WR: begin
        if (rdy) begin
          if (ptr_i_q + 3'd1 == n_q) begin
            state_d   = ST_IDLE;
            ptr_i_d   = 3'd0;
            ls_done_d = 1'b1;
          end else begin
            ptr_i_d = ptr_i_q + 3'd1;
          end
        end
      end

      ST_IO_WAIT: begin
        if (rdy && !io_buffer_full) state_d = ST_LS_WR;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      ptr_i_q    <= 3'd0;
      ptr_c_q    <= 3'd0;
      n_q        <= 3'd0;
      rdy_q      <= 1'b0;
      if_valid_q <= 1'b0;
      ls_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      ptr_i_q    <= ptr_i_d;
      ptr_c_q    <= ptr_c_d;
      n_q        <= n_d;
      rdy_q      <= rdy;
      if_valid_q <= if_valid_d;
      ls_done_q  <= ls_done_d;
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter: inputs change on the falling edge,
// outputs are sampled 1 time unit later, memory answers one cycle after its address.
module tb_ram_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic        io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_valid;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  logic [7:0]  mem [0:262143];
  logic        bk_we;
  logic [17:0] bk_addr;
  logic [7:0]  bk_dat;

  int checks;
  int errors;

  ram_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bk_we)       mem[bk_addr] <= bk_dat;
    else if (ram_wr) mem[ram_addr[17:0]] <= ram_dout;
    ram_din <= mem[ram_addr[17:0]];
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic bk(input logic [17:0] a, input logic [7:0] d);
    bk_addr = a;
    bk_dat  = d;
    bk_we   = 1'b1;
    @(negedge clk);
    bk_we   = 1'b0;
  endtask

  logic [31:0] exp_w;
  logic        seen;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_size = 2'b00; ls_wdata = '0;
    bk_we = 1'b0; bk_addr = '0; bk_dat = '0;
    @(negedge clk);
    bk(18'h00100, 8'h13); bk(18'h00101, 8'h05); bk(18'h00102, 8'h00); bk(18'h00103, 8'h00);
    bk(18'h00040, 8'h93); bk(18'h00041, 8'h00); bk(18'h00042, 8'h10); bk(18'h00043, 8'h00);
    bk(18'h1FFFF, 8'h7F); bk(18'h20000, 8'h80);
    bk(18'h00300, 8'h11); bk(18'h00301, 8'h22); bk(18'h00302, 8'h33); bk(18'h00303, 8'h44);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk); #1;

    // Reset state
    chk1("rst_ram_wr", ram_wr, 1'b0);
    chk32("rst_ram_addr", ram_addr, 32'h0);
    chk32("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_ls_done", ls_done, 1'b0);
    chk32("rst_if_data", if_data, 32'h0);
    chk32("rst_ls_rdata", ls_rdata, 32'h0);

    // Word fetch from 0x100
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); #1;
      if (k <= 4) begin
        chk32("f1_addr", ram_addr, 32'h100 + k - 1);
        chk1("f1_wr", ram_wr, 1'b0);
      end
      if (k == 6) begin
        chk1("f1_valid", if_valid, 1'b1);
        chk32("f1_data", if_data, 32'h00000513);
        if_req = 1'b0;
      end else begin
        chk1("f1_novalid", if_valid, 1'b0);
      end
    end

    // Store word with concurrent fetch; the store goes first, fetch reads it back
    @(negedge clk);
    exp_w = 32'hDEADBEEF;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_size = 2'b10; ls_wdata = exp_w;
    if_req = 1'b1; if_addr = 32'h200;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 2) ls_wdata = 32'h0;
      #1;
      if (k <= 4) begin
        chk1("st_wr", ram_wr, 1'b1);
        chk32("st_addr", ram_addr, 32'h200 + k - 1);
        chk32("st_dout", {24'h0, ram_dout}, {24'h0, exp_w[8*(k-1) +: 8]});
        chk1("st_nodone", ls_done, 1'b0);
      end
      if (k == 5) begin
        chk1("st_done", ls_done, 1'b1);
        chk1("st_wr_off", ram_wr, 1'b0);
        ls_req = 1'b0; ls_we = 1'b0;
      end
      if (k == 6) begin
        chk1("st_done_pulse", ls_done, 1'b0);
        chk32("st_f_addr", ram_addr, 32'h200);
        chk1("st_f_wr", ram_wr, 1'b0);
      end
      if (k == 11) begin
        chk1("st_f_valid", if_valid, 1'b1);
        chk32("st_f_data", if_data, 32'hDEADBEEF);
        if_req = 1'b0;
      end
    end

    // Flush in C3 of a fetch, then refetch at 0x40
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) begin if_flush = 1'b1; if_addr = 32'h40; end
      if (k == 4) if_flush = 1'b0;
      #1;
      if (k < 10 && if_valid) seen = 1'b1;
      if (k == 5) chk32("fl_addr", ram_addr, 32'h40);
      if (k == 10) begin
        chk1("fl_valid", if_valid, 1'b1);
        chk32("fl_data", if_data, 32'h00100093);
        if_req = 1'b0;
      end
    end
    chk1("fl_no_early_valid", seen, 1'b0);

    // IO write while the UART buffer is full
    @(negedge clk);
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h30000; ls_size = 2'b00; ls_wdata = 32'h41;
    seen = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 5) io_buffer_full = 1'b0;
      #1;
      if (k <= 5 && ram_wr) seen = 1'b1;
      if (k == 6) begin
        chk1("io_wr", ram_wr, 1'b1);
        chk32("io_addr", ram_addr, 32'h30000);
        chk32("io_dout", {24'h0, ram_dout}, 32'h41);
        chk1("io_nodone", ls_done, 1'b0);
      end
      if (k == 7) begin
        chk1("io_done", ls_done, 1'b1);
        chk1("io_wr_off", ram_wr, 1'b0);
        ls_req = 1'b0; ls_we = 1'b0;
      end
    end
    chk1("io_no_early_wr", seen, 1'b0);

    // Half load across 0x1FFFF/0x20000 with a 3-cycle pause
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h1FFFF; ls_size = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) rdy = 1'b0;
      if (k == 6) rdy = 1'b1;
      #1;
      if (k == 1) chk32("ld_addr0", ram_addr, 32'h1FFFF);
      if (k == 2) chk32("ld_addr1", ram_addr, 32'h20000);
      if (k >= 3 && k <= 5) chk1("ld_pause_wr", ram_wr, 1'b0);
      if (k == 6) chk32("ld_rewind_addr", ram_addr, 32'h20000);
      if (k < 8) chk1("ld_nodone", ls_done, 1'b0);
      if (k == 8) begin
        chk1("ld_done", ls_done, 1'b1);
        chk32("ld_rdata", ls_rdata, 32'h0000807F);
        ls_req = 1'b0;
      end
    end

    // Reset in C2 of a word load
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300; ls_size = 2'b10;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; ls_req = 1'b0;
    #1;
    chk32("ar_ram_addr", ram_addr, 32'h0);
    chk1("ar_ram_wr", ram_wr, 1'b0);
    chk32("ar_ram_dout", {24'h0, ram_dout}, 32'h0);
    chk1("ar_if_valid", if_valid, 1'b0);
    chk1("ar_ls_done", ls_done, 1'b0);
    chk32("ar_if_data", if_data, 32'h0);
    chk32("ar_ls_rdata", ls_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (ls_done) seen = 1'b1;
    end
    chk1("ar_no_done", seen, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
